// File: rtl/stream_insert_arb_pkg.sv
// Shared definitions for the stream_insert_arb scheduler: FSM state
// encoding and the default requester count.
package stream_insert_arb_pkg;

    localparam int NUM_SRC_DEF = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/stream_insert_arb_rr_arbiter.sv
// rr_arbiter: purely combinational grant selection for stream_insert_arb.
// Default build: round-robin, searching from the source after i_last.
// With INSERT_ARB_FIXED_PRIO_EN defined: lowest requesting index always wins
// and the last-grant input is removed.
module rr_arbiter
    import stream_insert_arb_pkg::*;
#(
    parameter int NUM_SRC   = NUM_SRC_DEF,
    parameter int SRC_ID_WD = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0]   i_req,
`ifndef INSERT_ARB_FIXED_PRIO_EN
    input  logic [SRC_ID_WD-1:0] i_last,
`endif
    output logic [NUM_SRC-1:0]   o_gnt,
    output logic [SRC_ID_WD-1:0] o_gnt_id,
    output logic                 o_gnt_vld
);

`ifdef INSERT_ARB_FIXED_PRIO_EN
    // Fixed priority: scan downwards so the lowest requesting index is the final winner.
    always_comb begin
        o_gnt     = '0;
        o_gnt_id  = '0;
        o_gnt_vld = 1'b0;
        for (int j = NUM_SRC - 1; j >= 0; j--) begin
            if (i_req[j]) begin
                o_gnt     = '0;
                o_gnt[j]  = 1'b1;
                o_gnt_id  = SRC_ID_WD'(j);
                o_gnt_vld = 1'b1;
            end
        end
    end
`else
    // One extra bit so last+k (at most 2*NUM_SRC-1) never overflows before the wrap.
    localparam int IW = SRC_ID_WD + 1;

    // Round robin: first requester at or after (last+1) mod NUM_SRC wins.
    always_comb begin
        logic [IW-1:0] v_idx;
        v_idx     = '0;
        o_gnt     = '0;
        o_gnt_id  = '0;
        o_gnt_vld = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            v_idx = {1'b0, i_last} + IW'(k);
            if (v_idx >= IW'(NUM_SRC)) begin
                v_idx = v_idx - IW'(NUM_SRC);
            end
            if (!o_gnt_vld && i_req[v_idx[SRC_ID_WD-1:0]]) begin
                o_gnt_vld                     = 1'b1;
                o_gnt[v_idx[SRC_ID_WD-1:0]]   = 1'b1;
                o_gnt_id                      = v_idx[SRC_ID_WD-1:0];
            end
        end
    end
`endif

endmodule

// File: rtl/stream_insert_arb.sv
// stream_insert_arb: shares one downstream stream_insert between NUM_SRC
// requesters. A granted source forwards one header beat and its payload up to
// last, then the arbiter releases and re-arbitrates after one idle bubble.
// Optional build macro: INSERT_ARB_FIXED_PRIO_EN (fixed lowest-index priority
// instead of round robin; ports and timing unchanged).
module stream_insert_arb
    import stream_insert_arb_pkg::*;
#(
    parameter int NUM_SRC      = NUM_SRC_DEF,
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD >> 3,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int SRC_ID_WD    = $clog2(NUM_SRC)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_SRC-1:0]                s_valid_insert,
    input  logic [NUM_SRC*DATA_WD-1:0]        s_data_insert,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0]   s_keep_insert,
    input  logic [NUM_SRC*BYTE_CNT_WD-1:0]    s_byte_insert_cnt,
    output logic [NUM_SRC-1:0]                s_ready_insert,
    input  logic [NUM_SRC-1:0]                s_valid_in,
    input  logic [NUM_SRC*DATA_WD-1:0]        s_data_in,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0]   s_keep_in,
    input  logic [NUM_SRC-1:0]                s_last_in,
    output logic [NUM_SRC-1:0]                s_ready_in,
    output logic                              m_valid_insert,
    output logic [DATA_WD-1:0]                m_data_insert,
    output logic [DATA_BYTE_WD-1:0]           m_keep_insert,
    output logic [BYTE_CNT_WD-1:0]            m_byte_insert_cnt,
    input  logic                              m_ready_insert,
    output logic                              m_valid_in,
    output logic [DATA_WD-1:0]                m_data_in,
    output logic [DATA_BYTE_WD-1:0]           m_keep_in,
    output logic                              m_last_in,
    input  logic                              m_ready_in,
    output logic [SRC_ID_WD-1:0]              grant_id,
    output logic                              busy
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SRC_ID_WD-1:0]  r_grant_id;
    logic [NUM_SRC-1:0]    r_grant_oh;
    logic                  r_hdr_done;
    logic                  r_pld_done;

    logic [NUM_SRC-1:0]    w_arb_oh;
    logic [SRC_ID_WD-1:0]  w_arb_id;
    logic                  w_arb_vld;

    logic                  w_sel_valid_insert;
    logic                  w_sel_valid_in;
    logic                  w_hdr_fire;
    logic                  w_last_fire;
    logic                  w_release;

`ifndef INSERT_ARB_FIXED_PRIO_EN
    logic [SRC_ID_WD-1:0]  r_last_grant;
`endif

    // Arbitration only looks at header valids; a payload-only source never wins.
    rr_arbiter #(
        .NUM_SRC   (NUM_SRC),
        .SRC_ID_WD (SRC_ID_WD)
    ) u_arb (
        .i_req     (s_valid_insert),
`ifndef INSERT_ARB_FIXED_PRIO_EN
        .i_last    (r_last_grant),
`endif
        .o_gnt     (w_arb_oh),
        .o_gnt_id  (w_arb_id),
        .o_gnt_vld (w_arb_vld)
    );

    // Select the granted source's channel fields via the registered one-hot grant.
    always_comb begin
        w_sel_valid_insert = 1'b0;
        w_sel_valid_in     = 1'b0;
        m_data_insert      = '0;
        m_keep_insert      = '0;
        m_byte_insert_cnt  = '0;
        m_data_in          = '0;
        m_keep_in          = '0;
        m_last_in          = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_grant_oh[i]) begin
                w_sel_valid_insert = s_valid_insert[i];
                w_sel_valid_in     = s_valid_in[i];
                m_data_insert      = s_data_insert[i*DATA_WD +: DATA_WD];
                m_keep_insert      = s_keep_insert[i*DATA_BYTE_WD +: DATA_BYTE_WD];
                m_byte_insert_cnt  = s_byte_insert_cnt[i*BYTE_CNT_WD +: BYTE_CNT_WD];
                m_data_in          = s_data_in[i*DATA_WD +: DATA_WD];
                m_keep_in          = s_keep_in[i*DATA_BYTE_WD +: DATA_BYTE_WD];
                m_last_in          = s_last_in[i];
            end
        end
    end

    // Next-state and handshake gating; IDLE drives no valid/ready so there is no s->m path.
    always_comb begin
        w_state_nxt    = r_state;
        m_valid_insert = 1'b0;
        m_valid_in     = 1'b0;
        s_ready_insert = '0;
        s_ready_in     = '0;
        w_hdr_fire     = 1'b0;
        w_last_fire    = 1'b0;
        w_release      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_vld) begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (!r_hdr_done) begin
                    m_valid_insert = w_sel_valid_insert;
                    s_ready_insert = r_grant_oh & {NUM_SRC{m_ready_insert}};
                end
                if (!r_pld_done) begin
                    m_valid_in = w_sel_valid_in;
                    s_ready_in = r_grant_oh & {NUM_SRC{m_ready_in}};
                end
                w_hdr_fire  = m_valid_insert & m_ready_insert;
                w_last_fire = m_valid_in & m_ready_in & m_last_in;
                w_release   = (r_hdr_done | w_hdr_fire) & (r_pld_done | w_last_fire);
                if (w_release) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant ownership and per-channel completion flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_id <= '0;
            r_grant_oh <= '0;
            r_hdr_done <= 1'b0;
            r_pld_done <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (w_arb_vld) begin
                r_grant_id <= w_arb_id;
                r_grant_oh <= w_arb_oh;
                r_hdr_done <= 1'b0;
                r_pld_done <= 1'b0;
            end
        end else begin
            if (w_hdr_fire) begin
                r_hdr_done <= 1'b1;
            end
            if (w_last_fire) begin
                r_pld_done <= 1'b1;
            end
        end
    end

`ifndef INSERT_ARB_FIXED_PRIO_EN
    // Round-robin pointer; reset value makes source 0 the first in line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= SRC_ID_WD'(NUM_SRC - 1);
        end else if (w_release) begin
            r_last_grant <= r_grant_id;
        end
    end
`endif

    assign grant_id = r_grant_id;
    assign busy     = (r_state == ST_ACTIVE);

endmodule

// File: tb/tb_stream_insert_arb.sv
// Directed self-checking bench for stream_insert_arb (NUM_SRC=4, DATA_WD=32).
// Inputs change 2 time units after the rising edge; outputs are checked one
// unit later, well away from the next edge.
module tb_stream_insert_arb;

    localparam int NUM_SRC      = 4;
    localparam int DATA_WD      = 32;
    localparam int DATA_BYTE_WD = 4;
    localparam int BYTE_CNT_WD  = 2;
    localparam int SRC_ID_WD    = 2;

    logic                            clk = 1'b0;
    logic                            rst;
    logic [NUM_SRC-1:0]              s_valid_insert;
    logic [NUM_SRC*DATA_WD-1:0]      s_data_insert;
    logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_insert;
    logic [NUM_SRC*BYTE_CNT_WD-1:0]  s_byte_insert_cnt;
    logic [NUM_SRC-1:0]              s_ready_insert;
    logic [NUM_SRC-1:0]              s_valid_in;
    logic [NUM_SRC*DATA_WD-1:0]      s_data_in;
    logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_in;
    logic [NUM_SRC-1:0]              s_last_in;
    logic [NUM_SRC-1:0]              s_ready_in;
    logic                            m_valid_insert;
    logic [DATA_WD-1:0]              m_data_insert;
    logic [DATA_BYTE_WD-1:0]         m_keep_insert;
    logic [BYTE_CNT_WD-1:0]          m_byte_insert_cnt;
    logic                            m_ready_insert;
    logic                            m_valid_in;
    logic [DATA_WD-1:0]              m_data_in;
    logic [DATA_BYTE_WD-1:0]         m_keep_in;
    logic                            m_last_in;
    logic                            m_ready_in;
    logic [SRC_ID_WD-1:0]            grant_id;
    logic                            busy;

    int n_checks = 0;
    int n_errs   = 0;
    int fire_cnt = 0;
    int c0;
    int exp_g6 [3];

    always #5 clk = ~clk;

    stream_insert_arb #(
        .NUM_SRC      (NUM_SRC),
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD),
        .BYTE_CNT_WD  (BYTE_CNT_WD),
        .SRC_ID_WD    (SRC_ID_WD)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .s_valid_insert    (s_valid_insert),
        .s_data_insert     (s_data_insert),
        .s_keep_insert     (s_keep_insert),
        .s_byte_insert_cnt (s_byte_insert_cnt),
        .s_ready_insert    (s_ready_insert),
        .s_valid_in        (s_valid_in),
        .s_data_in         (s_data_in),
        .s_keep_in         (s_keep_in),
        .s_last_in         (s_last_in),
        .s_ready_in        (s_ready_in),
        .m_valid_insert    (m_valid_insert),
        .m_data_insert     (m_data_insert),
        .m_keep_insert     (m_keep_insert),
        .m_byte_insert_cnt (m_byte_insert_cnt),
        .m_ready_insert    (m_ready_insert),
        .m_valid_in        (m_valid_in),
        .m_data_in         (m_data_in),
        .m_keep_in         (m_keep_in),
        .m_last_in         (m_last_in),
        .m_ready_in        (m_ready_in),
        .grant_id          (grant_id),
        .busy              (busy)
    );

    // Count payload beats accepted downstream.
    always @(posedge clk) begin
        if (m_valid_in && m_ready_in) fire_cnt <= fire_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic hdr(input int i, input logic v, input logic [31:0] d);
        s_valid_insert[i]                       = v;
        s_data_insert[i*DATA_WD +: DATA_WD]     = d;
        s_keep_insert[i*DATA_BYTE_WD +: 4]      = 4'hF;
        s_byte_insert_cnt[i*BYTE_CNT_WD +: 2]   = 2'(i);
    endtask

    task automatic pld(input int i, input logic v, input logic [31:0] d, input logic l);
        s_valid_in[i]                       = v;
        s_data_in[i*DATA_WD +: DATA_WD]     = d;
        s_keep_in[i*DATA_BYTE_WD +: 4]      = 4'hF;
        s_last_in[i]                        = l;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
`ifdef INSERT_ARB_FIXED_PRIO_EN
        exp_g6 = '{1, 1, 1};
`else
        exp_g6 = '{1, 3, 1};
`endif
        rst               = 1'b1;
        s_valid_insert    = '0;
        s_data_insert     = '0;
        s_keep_insert     = '0;
        s_byte_insert_cnt = '0;
        s_valid_in        = '0;
        s_data_in         = '0;
        s_keep_in         = '0;
        s_last_in         = '0;
        m_ready_insert    = 1'b1;
        m_ready_in        = 1'b1;

        // Reset state
        do_reset();
        settle();
        chk("rst_busy", busy, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_mvi", m_valid_insert, 0);
        chk("rst_mvp", m_valid_in, 0);
        chk("rst_sri", s_ready_insert, 0);
        chk("rst_srp", s_ready_in, 0);

        // Test 1: source 2, header + 4-beat payload, ready always high
        c0 = fire_cnt;
        hdr(2, 1, 32'hA2);
        pld(2, 1, 32'hB0, 0);
        settle();
        chk("t1_bubble_busy", busy, 0);
        chk("t1_bubble_mvi", m_valid_insert, 0);
        step(); settle();
        chk("t1_gid", grant_id, 2);
        chk("t1_busy", busy, 1);
        chk("t1_mvi", m_valid_insert, 1);
        chk("t1_mdi", m_data_insert, 32'hA2);
        chk("t1_mcnt", m_byte_insert_cnt, 2);
        chk("t1_mvp", m_valid_in, 1);
        chk("t1_mdp0", m_data_in, 32'hB0);
        chk("t1_sri", s_ready_insert, 4'b0100);
        chk("t1_srp", s_ready_in, 4'b0100);
        step();
        hdr(2, 0, 0);
        pld(2, 1, 32'hB1, 0);
        settle();
        chk("t1_hdr_done_mvi", m_valid_insert, 0);
        chk("t1_hdr_done_sri", s_ready_insert, 0);
        chk("t1_mdp1", m_data_in, 32'hB1);
        step();
        pld(2, 1, 32'hB2, 0);
        settle();
        chk("t1_mdp2", m_data_in, 32'hB2);
        step();
        pld(2, 1, 32'hB3, 1);
        settle();
        chk("t1_last", m_last_in, 1);
        chk("t1_busy_last", busy, 1);
        step();
        pld(2, 0, 0, 0);
        settle();
        chk("t1_busy_drop", busy, 0);
        chk("t1_mvp_idle", m_valid_in, 0);
        chk("t1_fires", fire_cnt - c0, 4);

        // Test 2: all sources requesting 1-beat packets, grant order 0,1,2,3,0,1
        do_reset();
        for (int i = 0; i < NUM_SRC; i++) begin
            hdr(i, 1, 32'hA0 + 32'(i));
            pld(i, 1, 32'hC0 + 32'(i), 1);
        end
        settle();
        chk("t2_bubble0", busy, 0);
        for (int k = 0; k < 6; k++) begin
            step(); settle();
            chk($sformatf("t2_gid%0d", k), grant_id, k % 4);
            chk($sformatf("t2_busy%0d", k), busy, 1);
            chk($sformatf("t2_mdi%0d", k), m_data_insert, 32'hA0 + 32'(k % 4));
            step(); settle();
            chk($sformatf("t2_idle%0d", k), busy, 0);
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            hdr(i, 0, 0);
            pld(i, 0, 0, 0);
        end

        // Test 3: header stalled 5 cycles while payload last fires first
        m_ready_insert = 1'b0;
        hdr(2, 1, 32'hA2);
        pld(2, 1, 32'hD0, 1);
        step(); settle();
        chk("t3_gid", grant_id, 2);
        chk("t3_sri_stall", s_ready_insert, 0);
        chk("t3_mvp", m_valid_in, 1);
        step();
        pld(2, 0, 0, 0);
        settle();
        chk("t3_busy_c2", busy, 1);
        chk("t3_mvp_done", m_valid_in, 0);
        chk("t3_mvi_held", m_valid_insert, 1);
        for (int c = 3; c <= 5; c++) begin
            step(); settle();
            chk($sformatf("t3_busy_c%0d", c), busy, 1);
            chk($sformatf("t3_mvp_c%0d", c), m_valid_in, 0);
        end
        step();
        m_ready_insert = 1'b1;
        hdr(0, 1, 32'hA0);
        pld(0, 1, 32'hE0, 1);
        hdr(3, 1, 32'hA3);
        pld(3, 1, 32'hE3, 1);
        settle();
        chk("t3_sri_rel", s_ready_insert, 4'b0100);
        chk("t3_busy_rel", busy, 1);
        step();
        hdr(2, 0, 0);
        settle();
        chk("t3_released", busy, 0);
        step(); settle();
        chk("t3_next_gid", grant_id, 3);
        step();
        hdr(0, 0, 0); pld(0, 0, 0, 0);
        hdr(3, 0, 0); pld(3, 0, 0, 0);
        settle();
        chk("t3_end_idle", busy, 0);

        // Test 4: source 1 requests during source 0's packet
        hdr(0, 1, 32'hA0);
        pld(0, 1, 32'hF0, 0);
        step();
        hdr(1, 1, 32'hA1);
        pld(1, 1, 32'hF1, 1);
        settle();
        chk("t4_gid", grant_id, 0);
        chk("t4_sri_a", s_ready_insert, 4'b0001);
        chk("t4_srp_a", s_ready_in, 4'b0001);
        step();
        hdr(0, 0, 0);
        pld(0, 1, 32'hF4, 0);
        settle();
        chk("t4_sri_b", s_ready_insert, 0);
        chk("t4_srp_b", s_ready_in, 4'b0001);
        step();
        pld(0, 1, 32'hF5, 1);
        settle();
        chk("t4_srp_c", s_ready_in, 4'b0001);
        chk("t4_last", m_last_in, 1);
        step();
        pld(0, 0, 0, 0);
        settle();
        chk("t4_bubble", busy, 0);
        chk("t4_srp_bubble", s_ready_in, 0);
        step(); settle();
        chk("t4_gid1", grant_id, 1);
        chk("t4_mdi1", m_data_insert, 32'hA1);
        chk("t4_mdp1", m_data_in, 32'hF1);
        step();
        hdr(1, 0, 0); pld(1, 0, 0, 0);
        settle();
        chk("t4_end_idle", busy, 0);

        // Test 5: reset during beat 2 of source 3's payload
        hdr(3, 1, 32'hA3);
        pld(3, 1, 32'h30, 0);
        step(); settle();
        chk("t5_gid3", grant_id, 3);
        step();
        hdr(3, 0, 0);
        pld(3, 1, 32'h31, 0);
        step();
        pld(3, 1, 32'h32, 0);
        settle();
        chk("t5_beat2", m_data_in, 32'h32);
        rst = 1'b1;
        hdr(0, 1, 32'hA0);
        pld(0, 1, 32'h50, 1);
        hdr(3, 1, 32'hA3);
        step();
        rst = 1'b0;
        settle();
        chk("t5_mvp", m_valid_in, 0);
        chk("t5_mvi", m_valid_insert, 0);
        chk("t5_busy", busy, 0);
        chk("t5_gid", grant_id, 0);
        chk("t5_srp", s_ready_in, 0);
        step(); settle();
        chk("t5_gid0", grant_id, 0);
        chk("t5_busy0", busy, 1);
        step();
        for (int i = 0; i < NUM_SRC; i++) begin
            hdr(i, 0, 0);
            pld(i, 0, 0, 0);
        end
        settle();
        chk("t5_end_idle", busy, 0);

        // Test 6: sources 1 and 3 continuously requesting
        do_reset();
        hdr(1, 1, 32'hA1); pld(1, 1, 32'h61, 1);
        hdr(3, 1, 32'hA3); pld(3, 1, 32'h63, 1);
        for (int k = 0; k < 3; k++) begin
            step(); settle();
            chk($sformatf("t6_gid%0d", k), grant_id, exp_g6[k]);
            step();
        end
        hdr(1, 0, 0); pld(1, 0, 0, 0);
        hdr(3, 0, 0); pld(3, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
